md5_core_scheduler: RTL

Top-level scheduler for a bank of NUM_CORES MD5 cracking cores, each running its own candidate generator and hash compare. It broadcasts the target hash and gives core k the start character charset_first+k with stride NUM_CORES, so the cores sweep interleaved, disjoint slices of the keyspace. It arbitrates the first match, freezes all cores and reports the plaintext, or reports exhaustion or timeout. It sits between the host/test interface and the per-core controllers.

---
 rtl/md5_core_scheduler_if.sv | 27 ++
 rtl/md5_core_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/md5_core_scheduler_if.sv
// Host-side job interface of the MD5 core scheduler: job request/abort in,
// status and winning result out.
interface md5_core_scheduler_if #(
   parameter int unsigned CORE_ID_W = 2
);
   logic                 start;
   logic                 abort;
   logic [127:0]         target_hash;
   logic [7:0]           charset_first;
   logic                 busy;
   logic                 found;
   logic                 not_found;
   logic                 timeout;
   logic [127:0]         result_plaintext;
   logic [CORE_ID_W-1:0] result_core;
   logic [31:0]          cycle_count;

   modport master (
      output start, abort, target_hash, charset_first,
      input  busy, found, not_found, timeout, result_plaintext, result_core, cycle_count
   );

   modport slave (
      input  start, abort, target_hash, charset_first,
      output busy, found, not_found, timeout, result_plaintext, result_core, cycle_count
   );
endinterface

// File: rtl/md5_core_scheduler.sv
// Job scheduler for a bank of MD5 cracking cores: loads interleaved keyspace
// slices, arbitrates the first match and reports match, exhaustion or timeout.
module md5_core_scheduler #(
   parameter int unsigned NUM_CORES   = 4,
   parameter int unsigned CORE_ID_W   = 2,
   parameter int unsigned LOAD_CYCLES = 2,
   parameter logic [31:0] MAX_CYCLES  = 32'hFFFF_FFFF
) (
   input  logic                     clk,
   input  logic                     reset,
   md5_core_scheduler_if.slave      host,
   output logic [127:0]             core_target_hash,
   output logic [NUM_CORES*8-1:0]   core_start_pos,
   output logic [2:0]               core_increment,
   output logic                     core_clear,
   output logic [NUM_CORES-1:0]     core_enable,
   input  logic [NUM_CORES-1:0]     core_found,
   input  logic [NUM_CORES-1:0]     core_done,
   input  logic [NUM_CORES*128-1:0] core_plaintext
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FOUND,
      S_EXHAUSTED
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [31:0]            load_cnt;
   logic [NUM_CORES-1:0]   done_mask;
   logic                   found_q;
   logic                   not_found_q;
   logic                   timeout_q;
   logic [127:0]           result_pt_q;
   logic [CORE_ID_W-1:0]   result_core_q;
   logic [31:0]            cycle_count_q;

   logic                   win_any;
   logic [CORE_ID_W-1:0]   win_idx;
   logic [127:0]           win_pt;
   logic [31:0]            cnt_nxt;
   logic                   hit_abort;
   logic                   hit_found;
   logic                   hit_done;
   logic                   hit_timeout;
   logic                   job_start;

   // Lowest-index matching core wins; higher indices are skipped once one is taken.
   always_comb begin
      win_any = 1'b0;
      win_idx = '0;
      win_pt  = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         if (!win_any && core_found[k]) begin
            win_any = 1'b1;
            win_idx = CORE_ID_W'(k);
            win_pt  = core_plaintext[k*128 +: 128];
         end
      end
   end

   // RUN exit conditions in priority order; done and timeout include this cycle.
   always_comb begin
      cnt_nxt     = (cycle_count_q == MAX_CYCLES) ? cycle_count_q : cycle_count_q + 32'd1;
      hit_abort   = (state == S_RUN) && host.abort;
      hit_found   = (state == S_RUN) && !host.abort && win_any;
      hit_done    = (state == S_RUN) && !host.abort && !win_any && (&(done_mask | core_done));
      hit_timeout = (state == S_RUN) && !host.abort && !win_any && !(&(done_mask | core_done))
                    && (cnt_nxt == MAX_CYCLES);
      job_start   = host.start && ((state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_FOUND, S_EXHAUSTED: begin
            if (job_start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (host.abort)                          state_nxt = S_IDLE;
            else if (load_cnt == 32'(LOAD_CYCLES - 1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (hit_abort)                     state_nxt = S_IDLE;
            else if (hit_found)                state_nxt = S_FOUND;
            else if (hit_done || hit_timeout)  state_nxt = S_EXHAUSTED;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_target_hash <= '0;
         core_start_pos   <= '0;
         core_increment   <= '0;
         load_cnt         <= '0;
         done_mask        <= '0;
         found_q          <= 1'b0;
         not_found_q      <= 1'b0;
         timeout_q        <= 1'b0;
         result_pt_q      <= '0;
         result_core_q    <= '0;
         cycle_count_q    <= '0;
      end else begin
         if (job_start) begin
            core_target_hash <= host.target_hash;
            core_increment   <= 3'(NUM_CORES);
            for (int unsigned k = 0; k < NUM_CORES; k++) begin
               core_start_pos[k*8 +: 8] <= host.charset_first + 8'(k);
            end
            load_cnt      <= '0;
            done_mask     <= '0;
            found_q       <= 1'b0;
            not_found_q   <= 1'b0;
            timeout_q     <= 1'b0;
            result_pt_q   <= '0;
            result_core_q <= '0;
            cycle_count_q <= '0;
         end
         if (state == S_LOAD) load_cnt <= load_cnt + 32'd1;
         if (state == S_RUN) begin
            cycle_count_q <= cnt_nxt;
            done_mask     <= done_mask | core_done;
         end
         if (hit_found) begin
            found_q       <= 1'b1;
            result_pt_q   <= win_pt;
            result_core_q <= win_idx;
         end
         if (hit_done || hit_timeout) not_found_q <= 1'b1;
         if (hit_timeout)             timeout_q   <= 1'b1;
      end
   end

   assign core_clear            = (state == S_LOAD);
   assign core_enable           = (state == S_RUN) ? '1 : '0;
   assign host.busy             = (state == S_LOAD) || (state == S_RUN);
   assign host.found            = found_q;
   assign host.not_found        = not_found_q;
   assign host.timeout          = timeout_q;
   assign host.result_plaintext = result_pt_q;
   assign host.result_core      = result_core_q;
   assign host.cycle_count      = cycle_count_q;

endmodule
